// File: rtl/fsic_wb_pkg.sv
// Shared types and widths for the FSIC Wishbone initiator: FSM state encoding
// and the packed command record that travels through the command FIFO.
package fsic_wb_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } fsm_state_e;

  // 69 bits: adr(32) wdata(32) sel(4) we(1)
  typedef struct packed {
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] wdata;
    logic [WB_SEL_W-1:0] sel;
    logic                we;
  } wb_cmd_t;

  localparam int CMD_W = $bits(wb_cmd_t);

endpackage

// File: rtl/fsic_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags; pointers carry one
// extra wrap bit so full and empty are distinguishable without a counter.
module fsic_sync_fifo #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok, pop_ok;

  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
               (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset; the pointers decide what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/fsic_wb_initiator.sv
// Wishbone classic initiator for the FSIC user-project slave port: buffered
// commands, one bus cycle at a time, one response each. Optional bus timeout
// abort is built when FSIC_WB_TIMEOUT_EN is defined.
module fsic_wb_initiator
  import fsic_wb_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                wb_clk,
  input  logic                wb_rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [WB_ADR_W-1:0] cmd_adr,
  input  logic [WB_DAT_W-1:0] cmd_wdata,
  input  logic [WB_SEL_W-1:0] cmd_sel,
  input  logic                cmd_we,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WB_DAT_W-1:0] rsp_rdata,
  output logic                rsp_err,
  output logic [WB_ADR_W-1:0] wbs_adr,
  output logic [WB_DAT_W-1:0] wbs_wdata,
  output logic [WB_SEL_W-1:0] wbs_sel,
  output logic                wbs_cyc,
  output logic                wbs_stb,
  output logic                wbs_we,
  input  logic                wbs_ack,
  input  logic [WB_DAT_W-1:0] wbs_rdata,
  output fsm_state_e          dbg_state_o
);

  if ((CMD_DEPTH < 2) || ((CMD_DEPTH & (CMD_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("CMD_DEPTH must be a power of two >= 2");
  end
  if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_bad_timeout
    $error("TIMEOUT must be in 1..65535");
  end

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // A valid source holds its payload stable until that edge; ready never
  // depends combinationally on valid.

  fsm_state_e          state_q, state_d;
  logic [WB_ADR_W-1:0] adr_q, adr_d;
  logic [WB_DAT_W-1:0] wdata_q, wdata_d;
  logic [WB_SEL_W-1:0] sel_q, sel_d;
  logic                we_q, we_d;
  logic                cyc_q, cyc_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [WB_DAT_W-1:0] rsp_rdata_q, rsp_rdata_d;

  wb_cmd_t cmd_in, cmd_head;
  logic    fifo_full, fifo_empty, fifo_pop;

  assign cmd_in = '{adr: cmd_adr, wdata: cmd_wdata, sel: cmd_sel, we: cmd_we};

  fsic_sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk_i   (wb_clk),
    .rst_i   (wb_rst),
    .push_i  (cmd_valid && !fifo_full),
    .data_i  (cmd_in),
    .pop_i   (fifo_pop),
    .data_o  (cmd_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef FSIC_WB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    we_d        = we_q;
    cyc_d       = cyc_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    fifo_pop    = 1'b0;
`ifdef FSIC_WB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          adr_d    = cmd_head.adr;
          wdata_d  = cmd_head.wdata;
          sel_d    = cmd_head.sel;
          we_d     = cmd_head.we;
          cyc_d    = 1'b1;
`ifdef FSIC_WB_TIMEOUT_EN
          cnt_d    = '0;
`endif
          state_d  = ST_BUS;
        end
      end
      ST_BUS: begin
        // Ack is checked first so it wins over a coincident timeout.
        if (wbs_ack) begin
          cyc_d       = 1'b0;
          rsp_rdata_d = we_q ? '0 : wbs_rdata;
          rsp_valid_d = 1'b1;
`ifdef FSIC_WB_TIMEOUT_EN
          err_d       = 1'b0;
`endif
          state_d     = ST_RESP;
        end
`ifdef FSIC_WB_TIMEOUT_EN
        else if (cnt_q == TMO_LAST) begin
          cyc_d       = 1'b0;
          rsp_rdata_d = '0;
          err_d       = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      ST_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q     <= ST_IDLE;
      adr_q       <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      cyc_q       <= cyc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef FSIC_WB_TIMEOUT_EN
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign cmd_ready   = !fifo_full;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign wbs_adr     = adr_q;
  assign wbs_wdata   = wdata_q;
  assign wbs_sel     = sel_q;
  assign wbs_we      = we_q;
  assign wbs_cyc     = cyc_q;
  assign wbs_stb     = cyc_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fsic_wb_initiator.sv
// Directed bench for fsic_wb_initiator with a parameterisable-latency
// Wishbone responder; FSIC_WB_TIMEOUT_EN selects the timeout scenarios.
module tb_fsic_wb_initiator;
  import fsic_wb_pkg::*;

`ifdef FSIC_WB_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic        wb_clk;
  logic        wb_rst;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_adr, cmd_wdata;
  logic [3:0]  cmd_sel;
  logic        cmd_we;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] wbs_adr, wbs_wdata;
  logic [3:0]  wbs_sel;
  logic        wbs_cyc, wbs_stb, wbs_we;
  logic        wbs_ack;
  logic [31:0] wbs_rdata;
  fsm_state_e  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [32:0] exp_q[$];

  fsic_wb_initiator #(.CMD_DEPTH(4), .TIMEOUT(TMO)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_adr(cmd_adr), .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel), .cmd_we(cmd_we),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wbs_adr(wbs_adr), .wbs_wdata(wbs_wdata), .wbs_sel(wbs_sel),
    .wbs_cyc(wbs_cyc), .wbs_stb(wbs_stb), .wbs_we(wbs_we),
    .wbs_ack(wbs_ack), .wbs_rdata(wbs_rdata),
    .dbg_state_o(dbg_state)
  );

  // Clock / reset block
  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  // Responder: acks after wait_states cycles of cyc; reads return ~adr or a fixed word.
  logic        ack_en = 1'b1;
  int          wait_states = 0;
  logic        rd_fixed = 1'b0;
  logic [31:0] rd_val = '0;
  int          resp_cnt = 0;

  always @(posedge wb_clk) begin
    if (!wbs_cyc || wbs_ack) resp_cnt <= 0;
    else                     resp_cnt <= resp_cnt + 1;
  end
  assign wbs_ack   = wbs_cyc && ack_en && (resp_cnt == wait_states);
  assign wbs_rdata = rd_fixed ? rd_val : ~wbs_adr;

  // Driver tasks
  task automatic push_cmd(input logic [31:0] adr, input logic [31:0] wdata,
                          input logic [3:0] sel, input logic we, output logic ok);
    int n;
    n = 0;
    cmd_adr = adr; cmd_wdata = wdata; cmd_sel = sel; cmd_we = we; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      @(posedge wb_clk); #1; n++;
    end
    ok = cmd_ready;
    @(posedge wb_clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_bus_rsp(input int budget, output int cyc_cycles,
                              output logic [31:0] adr, output logic [31:0] wdata,
                              output logic [3:0] sel, output logic we,
                              output logic changed, output logic got);
    int n;
    n = 0; cyc_cycles = 0; changed = 1'b0; got = 1'b0;
    adr = '0; wdata = '0; sel = '0; we = 1'b0;
    while (!got && n < budget) begin
      @(posedge wb_clk); #1; n++;
      if (wbs_cyc !== wbs_stb) changed = 1'b1;
      if (wbs_cyc === 1'b1) begin
        if (cyc_cycles == 0) begin
          adr = wbs_adr; wdata = wbs_wdata; sel = wbs_sel; we = wbs_we;
        end else if (wbs_adr !== adr || wbs_wdata !== wdata || wbs_sel !== sel || wbs_we !== we) begin
          changed = 1'b1;
        end
        cyc_cycles++;
      end
      if (rsp_valid === 1'b1) got = 1'b1;
    end
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge wb_clk); #1;
    rsp_ready = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    wb_rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_adr = '0; cmd_wdata = '0; cmd_sel = '0; cmd_we = 1'b0;
    repeat (3) @(posedge wb_clk);
    #1;
    n_checks++; if (cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); else n_pass++;
    n_checks++; if (rsp_rdata !== 32'h0) $display("FAIL rst_rsp_rdata got %h exp 0", rsp_rdata); else n_pass++;
    n_checks++; if (rsp_err !== 1'b0) $display("FAIL rst_rsp_err got %b exp 0", rsp_err); else n_pass++;
    n_checks++; if ({wbs_cyc, wbs_stb, wbs_we} !== 3'b000) $display("FAIL rst_bus_ctrl got %b exp 000", {wbs_cyc, wbs_stb, wbs_we}); else n_pass++;
    n_checks++; if ({wbs_adr, wbs_wdata, wbs_sel} !== 68'h0) $display("FAIL rst_bus_data got %h exp 0", {wbs_adr, wbs_wdata, wbs_sel}); else n_pass++;
    n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL rst_state got %0d exp %0d", dbg_state, ST_IDLE); else n_pass++;
    wb_rst = 1'b0;
    @(posedge wb_clk); #1;
  endtask

  task automatic test_single_write();
    int cc; logic [31:0] a, d; logic [3:0] s; logic w, ch, got, ok;
    ack_en = 1'b1; wait_states = 0; rd_fixed = 1'b0;
    push_cmd(32'h3000_0004, 32'hA5A5_1234, 4'hF, 1'b1, ok);
    wait_bus_rsp(20, cc, a, d, s, w, ch, got);
    n_checks++; if (got !== 1'b1) $display("FAIL wr_rsp_seen got %b exp 1", got); else n_pass++;
    n_checks++; if (cc != 1) $display("FAIL wr_cyc_len got %0d exp 1", cc); else n_pass++;
    n_checks++; if ({a, d, s, w} !== {32'h3000_0004, 32'hA5A5_1234, 4'hF, 1'b1}) $display("FAIL wr_bus got %h %h %h %b exp 30000004 a5a51234 f 1", a, d, s, w); else n_pass++;
    n_checks++; if (ch !== 1'b0) $display("FAIL wr_bus_stable got %b exp 0", ch); else n_pass++;
    n_checks++; if ({rsp_err, rsp_rdata} !== 33'h0) $display("FAIL wr_rsp got err %b rdata %h exp 0 0", rsp_err, rsp_rdata); else n_pass++;
    take_rsp();
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL wr_rsp_clear got %b exp 0", rsp_valid); else n_pass++;
  endtask

  task automatic test_read_wait();
    int cc; logic [31:0] a, d; logic [3:0] s; logic w, ch, got, ok;
    ack_en = 1'b1; wait_states = 3; rd_fixed = 1'b1; rd_val = 32'hCAFE_F00D;
    push_cmd(32'h3000_0010, 32'hDEAD_BEEF, 4'h3, 1'b0, ok);
    wait_bus_rsp(30, cc, a, d, s, w, ch, got);
    n_checks++; if (got !== 1'b1) $display("FAIL rd_rsp_seen got %b exp 1", got); else n_pass++;
    n_checks++; if (cc != 4) $display("FAIL rd_cyc_len got %0d exp 4", cc); else n_pass++;
    n_checks++; if ({a, s, w} !== {32'h3000_0010, 4'h3, 1'b0}) $display("FAIL rd_bus got %h %h %b exp 30000010 3 0", a, s, w); else n_pass++;
    n_checks++; if (ch !== 1'b0) $display("FAIL rd_bus_stable got %b exp 0", ch); else n_pass++;
    n_checks++; if ({rsp_err, rsp_rdata} !== {1'b0, 32'hCAFE_F00D}) $display("FAIL rd_rsp got err %b rdata %h exp 0 cafef00d", rsp_err, rsp_rdata); else n_pass++;
    take_rsp();
    rd_fixed = 1'b0; wait_states = 0;
  endtask

  task automatic test_fill_order();
    int cc, n; logic [31:0] a, d; logic [3:0] s; logic w, ch, got, ok, seen_cyc, seen_e;
    logic [32:0] exp;
    ack_en = 1'b1; wait_states = 0; rd_fixed = 1'b0; rsp_ready = 1'b0;
    push_cmd(32'h3000_0080, 32'h0000_0001, 4'hF, 1'b1, ok);
    wait_bus_rsp(20, cc, a, d, s, w, ch, got);
    n_checks++; if (got !== 1'b1) $display("FAIL fill_first_rsp got %b exp 1", got); else n_pass++;
    push_cmd(32'h3000_0100, 32'h0, 4'hF, 1'b0, ok);
    push_cmd(32'h3000_0104, 32'h1111_2222, 4'h1, 1'b1, ok);
    push_cmd(32'h3000_0200, 32'h0, 4'hC, 1'b0, ok);
    push_cmd(32'h3000_0300, 32'h0, 4'h0, 1'b0, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL fill_push_ok got %b exp 1", ok); else n_pass++;
    n_checks++; if (cmd_ready !== 1'b0) $display("FAIL fill_full got cmd_ready %b exp 0", cmd_ready); else n_pass++;
    exp_q.push_back({1'b0, 32'h0});
    exp_q.push_back({1'b0, 32'hCFFF_FEFF});
    exp_q.push_back({1'b0, 32'h0});
    exp_q.push_back({1'b0, 32'hCFFF_FDFF});
    exp_q.push_back({1'b0, 32'hCFFF_FCFF});
    rsp_ready = 1'b1; seen_cyc = 1'b0; seen_e = 1'b0; n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      if (rsp_valid === 1'b1) begin
        exp = exp_q.pop_front();
        n_checks++; if ({rsp_err, rsp_rdata} !== exp) $display("FAIL fill_rsp_order got %h exp %h", {rsp_err, rsp_rdata}, exp); else n_pass++;
      end
      if (wbs_cyc === 1'b1 && !seen_cyc) begin
        seen_cyc = 1'b1;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL fill_ready_after_pop got %b exp 1", cmd_ready); else n_pass++;
      end
      if (wbs_cyc === 1'b1 && wbs_adr === 32'h3000_0300 && !seen_e) begin
        seen_e = 1'b1;
        n_checks++; if (wbs_sel !== 4'h0) $display("FAIL fill_sel_zero got %h exp 0", wbs_sel); else n_pass++;
      end
      @(posedge wb_clk); #1; n++;
    end
    rsp_ready = 1'b0;
    n_checks++; if (exp_q.size() != 0) $display("FAIL fill_drain got %0d left exp 0", exp_q.size()); else n_pass++;
    n_checks++; if (seen_e !== 1'b1) $display("FAIL fill_sel_zero_seen got %b exp 1", seen_e); else n_pass++;
    exp_q.delete();
  endtask

`ifdef FSIC_WB_TIMEOUT_EN
  task automatic test_timeout();
    int cc; logic [31:0] a, d; logic [3:0] s; logic w, ch, got, ok;
    ack_en = 1'b0; rd_fixed = 1'b1; rd_val = 32'h1234_5678;
    push_cmd(32'h3000_0040, 32'h0, 4'hF, 1'b0, ok);
    wait_bus_rsp(40, cc, a, d, s, w, ch, got);
    n_checks++; if (got !== 1'b1) $display("FAIL tmo_rsp_seen got %b exp 1", got); else n_pass++;
    n_checks++; if (cc != 8) $display("FAIL tmo_cyc_len got %0d exp 8", cc); else n_pass++;
    n_checks++; if ({rsp_err, rsp_rdata} !== {1'b1, 32'h0}) $display("FAIL tmo_rsp got err %b rdata %h exp 1 0", rsp_err, rsp_rdata); else n_pass++;
    take_rsp();
    ack_en = 1'b1; wait_states = 7;
    push_cmd(32'h3000_0044, 32'h0, 4'hF, 1'b0, ok);
    wait_bus_rsp(40, cc, a, d, s, w, ch, got);
    n_checks++; if (got !== 1'b1) $display("FAIL tmo_ack_rsp_seen got %b exp 1", got); else n_pass++;
    n_checks++; if (cc != 8) $display("FAIL tmo_ack_cyc_len got %0d exp 8", cc); else n_pass++;
    n_checks++; if ({rsp_err, rsp_rdata} !== {1'b0, 32'h1234_5678}) $display("FAIL tmo_ack_rsp got err %b rdata %h exp 0 12345678", rsp_err, rsp_rdata); else n_pass++;
    take_rsp();
    wait_states = 0; rd_fixed = 1'b0;
  endtask
`else
  task automatic test_long_wait();
    int cc; logic [31:0] a, d; logic [3:0] s; logic w, ch, got, ok;
    ack_en = 1'b1; wait_states = 300; rd_fixed = 1'b1; rd_val = 32'h0BAD_CAFE;
    push_cmd(32'h3000_0048, 32'h0, 4'hF, 1'b0, ok);
    wait_bus_rsp(400, cc, a, d, s, w, ch, got);
    n_checks++; if (got !== 1'b1) $display("FAIL long_rsp_seen got %b exp 1", got); else n_pass++;
    n_checks++; if (cc != 301) $display("FAIL long_cyc_len got %0d exp 301", cc); else n_pass++;
    n_checks++; if (ch !== 1'b0) $display("FAIL long_bus_stable got %b exp 0", ch); else n_pass++;
    n_checks++; if ({rsp_err, rsp_rdata} !== {1'b0, 32'h0BAD_CAFE}) $display("FAIL long_rsp got err %b rdata %h exp 0 0badcafe", rsp_err, rsp_rdata); else n_pass++;
    take_rsp();
    wait_states = 0; rd_fixed = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    int cc; logic [31:0] a, d; logic [3:0] s; logic w, ch, got, ok, stray;
    ack_en = 1'b0; wait_states = 0; rd_fixed = 1'b0; rsp_ready = 1'b0;
    push_cmd(32'h3000_0500, 32'h0, 4'hF, 1'b0, ok);
    push_cmd(32'h3000_0504, 32'h0, 4'hF, 1'b0, ok);
    push_cmd(32'h3000_0508, 32'h0, 4'hF, 1'b0, ok);
    n_checks++; if (wbs_cyc !== 1'b1) $display("FAIL rstmid_in_bus got %b exp 1", wbs_cyc); else n_pass++;
    wb_rst = 1'b1;
    @(posedge wb_clk); #1;
    n_checks++; if ({wbs_cyc, wbs_stb} !== 2'b00) $display("FAIL rstmid_cyc got %b exp 00", {wbs_cyc, wbs_stb}); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rstmid_rsp_valid got %b exp 0", rsp_valid); else n_pass++;
    n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL rstmid_state got %0d exp %0d", dbg_state, ST_IDLE); else n_pass++;
    wb_rst = 1'b0; ack_en = 1'b1;
    stray = 1'b0;
    repeat (6) begin
      @(posedge wb_clk); #1;
      if (wbs_cyc !== 1'b0 || rsp_valid !== 1'b0) stray = 1'b1;
    end
    n_checks++; if (stray !== 1'b0) $display("FAIL rstmid_flushed got activity %b exp 0", stray); else n_pass++;
    push_cmd(32'h3000_0404, 32'h0, 4'hF, 1'b0, ok);
    wait_bus_rsp(20, cc, a, d, s, w, ch, got);
    n_checks++; if (got !== 1'b1) $display("FAIL rstmid_new_seen got %b exp 1", got); else n_pass++;
    n_checks++; if (cc != 1) $display("FAIL rstmid_new_cyc got %0d exp 1", cc); else n_pass++;
    n_checks++; if ({rsp_err, rsp_rdata} !== {1'b0, 32'hCFFF_FBFB}) $display("FAIL rstmid_new_rsp got err %b rdata %h exp 0 cffffbfb", rsp_err, rsp_rdata); else n_pass++;
    take_rsp();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_wait();
    test_fill_order();
`ifdef FSIC_WB_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
